// File: rtl/gcd_processor_pkg.sv
// Shared definitions for the GCD accumulator processor: widths, opcodes,
// FSM state encodings and the built-in program image.
package gcd_processor_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int MEM_DEPTH  = 32;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  // Execute states are 8 + opcode, so decode is a single concatenation.
  typedef enum logic [3:0] {
    S_START  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_LOAD   = 4'd8,
    S_STORE  = 4'd9,
    S_ADD    = 4'd10,
    S_SUB    = 4'd11,
    S_IN     = 4'd12,
    S_JZ     = 4'd13,
    S_JPOS   = 4'd14,
    S_HALT   = 4'd15
  } state_t;

  // GCD by repeated subtraction; X lives at word 30, Y at word 31.
  localparam logic [DEF_DATA_W-1:0] PROG_IMAGE [MEM_DEPTH] = '{
    8'h80,  //  0 IN
    8'h3E,  //  1 STORE 30
    8'h80,  //  2 IN
    8'h3F,  //  3 STORE 31
    8'h1E,  //  4 LOAD 30
    8'h7F,  //  5 SUB 31
    8'hAE,  //  6 JZ 14
    8'hCC,  //  7 JPOS 12
    8'h1F,  //  8 LOAD 31
    8'h7E,  //  9 SUB 30
    8'h3F,  // 10 STORE 31
    8'hC4,  // 11 JPOS 4
    8'h3E,  // 12 STORE 30
    8'hC4,  // 13 JPOS 4
    8'h1E,  // 14 LOAD 30
    8'hE0,  // 15 HALT
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic state_t execState(input opcode_t op);
    return state_t'({1'b1, op});
  endfunction

endpackage

// File: rtl/gcd_processor_if.sv
// Operand handshake and result bus between the GCD processor and its host.
interface gcd_processor_if
  import gcd_processor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              enter;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              halt;

  modport master (output enter, output in, input out, input halt);
  modport slave  (input enter, input in, output out, output halt);
endinterface

// File: rtl/gcd_ram.sv
// 32x8 unified instruction/data RAM: asynchronous read, synchronous write,
// synchronous reload of the program image on init.
module gcd_ram
  import gcd_processor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              clk,
  input  logic              init,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset term; init is the only way to restore the
  // image, which keeps the storage mappable onto distributed RAM.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PROG_IMAGE[i];
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/gcd_processor.sv
// 8-bit accumulator processor running the built-in GCD program; FSM and
// datapath live here, storage is in gcd_ram.
module gcd_processor
  import gcd_processor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  gcd_processor_if.slave    bus,
  output logic [ADDR_W-1:0] IR40,
  output logic [ADDR_W-1:0] MeminstOut,
  output logic [DATA_W-1:0] regAOut,
  output logic [DATA_W-1:0] RAMout,
  output logic [3:0]        DisplayState,
  output logic [2:0]        IR75
);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  state_t            state;

  logic [ADDR_W-1:0] irAddr;
  logic              ramWe;

  assign irAddr     = ir[ADDR_W-1:0];
  assign MeminstOut = (state == S_FETCH) ? pc : irAddr;
  assign ramWe      = (state == S_STORE);

  gcd_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .init  (init),
    .we    (ramWe),
    .addr  (MeminstOut),
    .wdata (a),
    .rdata (RAMout)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= '0;
      ir    <= '0;
      a     <= '0;
      state <= S_START;
    end else begin
      case (state)
        S_START:  state <= S_FETCH;
        S_FETCH: begin
          ir    <= RAMout;
          pc    <= pc + 1'b1;
          state <= S_DECODE;
        end
        S_DECODE: state <= execState(opcode_t'(ir[DATA_W-1 -: 3]));
        S_LOAD: begin
          a     <= RAMout;
          state <= S_START;
        end
        S_STORE:  state <= S_START;
        S_ADD: begin
          a     <= a + RAMout;
          state <= S_START;
        end
        S_SUB: begin
          a     <= a - RAMout;
          state <= S_START;
        end
        S_IN: begin
          if (bus.enter) begin
            a     <= bus.in;
            state <= S_START;
          end
        end
        S_JZ: begin
          if (a == '0) pc <= irAddr;
          state <= S_START;
        end
        S_JPOS: begin
          // Strictly positive in two's complement: sign clear and non-zero.
          if (!a[DATA_W-1] && (a != '0)) pc <= irAddr;
          state <= S_START;
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_START;
      endcase
    end
  end

  assign bus.out      = a;
  assign bus.halt     = (state == S_HALT);
  assign regAOut      = a;
  assign IR40         = irAddr;
  assign IR75         = ir[DATA_W-1 -: 3];
  assign DisplayState = state;

endmodule

// File: tb/tb_gcd_processor.sv
// Directed self-checking bench for gcd_processor: reset/idle, debug ports,
// several GCD runs, enter hold, reset mid-run and init+reset.
module tb_gcd_processor;
  import gcd_processor_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [4:0] IR40;
  logic [4:0] MeminstOut;
  logic [7:0] regAOut;
  logic [7:0] RAMout;
  logic [3:0] DisplayState;
  logic [2:0] IR75;

  int nAsserts = 0;
  int nFails   = 0;

  gcd_processor_if bus ();

  gcd_processor dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .bus          (bus),
    .IR40         (IR40),
    .MeminstOut   (MeminstOut),
    .regAOut      (regAOut),
    .RAMout       (RAMout),
    .DisplayState (DisplayState),
    .IR75         (IR75)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitState(input string tag, input logic [3:0] s, input int budget);
    int k = 0;
    while (DisplayState !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, {28'd0, DisplayState}, {28'd0, s});
  endtask

  task automatic waitHalt(input string tag, input int budget);
    int k = 0;
    while (bus.halt !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'd0, bus.halt}, 32'd1);
  endtask

  task automatic applyReset(input string tag, input logic withInit);
    reset = 1'b1;
    init  = withInit;
    bus.enter = 1'b0;
    tick();
    check({tag, "_out"},   {24'd0, bus.out},      32'd0);
    check({tag, "_halt"},  {31'd0, bus.halt},     32'd0);
    check({tag, "_state"}, {28'd0, DisplayState}, 32'd0);
    check({tag, "_ir"},    {24'd0, IR75, IR40},   32'd0);
    reset = 1'b0;
    init  = 1'b0;
  endtask

  task automatic enterOperand(input string tag, input logic [7:0] v);
    waitState({tag, "_reachIn"}, S_IN, 50);
    bus.enter = 1'b1;
    bus.in    = v;
    tick();
    bus.enter = 1'b0;
    check({tag, "_capA"},  {24'd0, regAOut},      {24'd0, v});
    check({tag, "_start"}, {28'd0, DisplayState}, {28'd0, S_START});
  endtask

  task automatic finishGcd(input string tag, input logic [7:0] exp, input int budget);
    waitHalt({tag, "_halt"}, budget);
    check({tag, "_out"}, {24'd0, bus.out}, {24'd0, exp});
    for (int i = 0; i < 10; i++) begin
      tick();
      check({tag, "_holdHalt"}, {31'd0, bus.halt}, 32'd1);
      check({tag, "_holdOut"},  {24'd0, bus.out},  {24'd0, exp});
      check({tag, "_holdA"},    {24'd0, regAOut},  {24'd0, exp});
    end
  endtask

  task automatic runGcd(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp);
    enterOperand({tag, "_x"}, x);
    enterOperand({tag, "_y"}, y);
    finishGcd(tag, exp, 8000);
  endtask

  initial begin
    bus.enter = 1'b0;
    bus.in    = '0;

    // Load the program image and reset together, then check the idle path.
    applyReset("rst0", 1'b1);
    tick();
    check("fetch_state", {28'd0, DisplayState}, {28'd0, S_FETCH});
    check("fetch_addr",  {27'd0, MeminstOut},   32'd0);
    check("fetch_word",  {24'd0, RAMout},       32'h80);
    tick();
    check("decode_state", {28'd0, DisplayState}, {28'd0, S_DECODE});
    check("decode_op",    {29'd0, IR75},         32'd4);
    tick();
    check("in_after3", {28'd0, DisplayState}, {28'd0, S_IN});
    tick(5);
    check("in_hold",      {28'd0, DisplayState}, {28'd0, S_IN});
    check("in_hold_halt", {31'd0, bus.halt},     32'd0);

    // GCD basic, with debug-port checks on the STORE 30 fetch/decode.
    bus.enter = 1'b1;
    bus.in    = 8'd12;
    tick();
    bus.enter = 1'b0;
    check("basic_capX", {24'd0, regAOut}, 32'd12);
    tick();
    check("st30_fetch_addr", {27'd0, MeminstOut}, 32'd1);
    check("st30_fetch_word", {24'd0, RAMout},     32'h3E);
    tick();
    check("st30_ir75", {29'd0, IR75}, 32'd1);
    check("st30_ir40", {27'd0, IR40}, 32'd30);
    enterOperand("basic_y", 8'd18);
    finishGcd("basic", 8'd6, 8000);

    // Equal operands; enter held high past capture must not disturb A.
    applyReset("rst1", 1'b0);
    waitState("eq_reachIn", S_IN, 50);
    bus.enter = 1'b1;
    bus.in    = 8'd7;
    tick();
    bus.in = 8'd99;
    tick(3);
    check("eq_heldA", {24'd0, regAOut}, 32'd7);
    bus.enter = 1'b0;
    enterOperand("eq_y", 8'd7);
    finishGcd("eq", 8'd7, 40);

    applyReset("rst2", 1'b0);
    runGcd("long", 8'd1, 8'd127, 8'd1);

    applyReset("rst3", 1'b0);
    runGcd("r100_75", 8'd100, 8'd75, 8'd25);

    // Reset in the middle of the subtract loop.
    applyReset("rst4", 1'b0);
    enterOperand("mid_x", 8'd1);
    enterOperand("mid_y", 8'd127);
    tick(60);
    check("mid_notHalted", {31'd0, bus.halt}, 32'd0);
    applyReset("rst5", 1'b0);
    runGcd("after_mid", 8'd48, 8'd36, 8'd12);

    applyReset("rst6", 1'b1);
    runGcd("after_init", 8'd9, 8'd6, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
